bsg_async_fifo_wptr_gray: RTL and testbench
===========================================

# bsg_async_fifo_wptr_gray

Write-side pointer unit for a dual-clock FIFO. It keeps the binary and Gray-coded write pointers and synchronizes the read-domain Gray pointer into the write clock domain. It also produces a registered-state full flag and a sticky overflow flag. It sits directly upstream of the read side's Gray-to-binary converter: `w_ptr_gray_o` is the only signal that crosses domains, and a 16-bit pointer (default) matches the 16-bit Gray-to-binary stage.

## Interface
- `lg_size_p`, default 15: log2 of FIFO depth; pointer width `ptr_w = lg_size_p+1` (default 16); legal range `lg_size_p >= 1`.
- `clk_i` in, 1: write-domain clock.
- `reset_n_i` in, 1: synchronous, active-low reset.
- `w_enq_i` in, 1: write request for this cycle.
- `w_full_o` out, 1: FIFO full; a request is accepted only when `w_full_o=0`.
- `w_accept_o` out, 1: `w_enq_i & ~w_full_o`; the FIFO RAM write enable.
- `w_ptr_binary_o` out, ptr_w: registered binary write pointer; the low `lg_size_p` bits are the RAM write address.
- `w_ptr_gray_o` out, ptr_w: registered Gray write pointer, driven directly from flops, to the read domain.
- `r_ptr_gray_i` in, ptr_w: read-domain Gray pointer, asynchronous to `clk_i`.
- `r_ptr_gray_sync_o` out, ptr_w: `r_ptr_gray_i` after a 2-flop synchronizer.
- `w_overflow_o` out, 1: sticky flag; set when `w_enq_i=1` while `w_full_o=1`.

## Operation
- Binary pointer `b` increments by 1 modulo `2^ptr_w` on each accepted write.
- Gray pointer register loads `gray(b_next)` in the same edge as `b`. `gray(x) = x ^ (x>>1)`.
- The Gray output must come straight from flops, with no combinational logic after them. Consecutive values differ in exactly one bit, including across the wrap-around.
- Synchronizer: two back-to-back `ptr_w`-wide flop stages, `s1 <= r_ptr_gray_i` and `s2 <= s1`. The output is `r_ptr_gray_sync_o = s2`. There is no logic between the stages.
- Full: `w_full_o = (w_ptr_gray_o == {~s2[ptr_w-1:ptr_w-2], s2[ptr_w-3:0]})`.
  - This is a combinational compare of flop outputs only; there is no path from `w_enq_i`.
  - When `lg_size_p=1`, the compare is `w_ptr_gray_o == ~s2`.
- Write while full:
  - the pointers hold;
  - `w_accept_o=0`;
  - `w_overflow_o` is set on the next edge and stays high until reset.
- Reset (`reset_n_i=0` at an edge): `b`, the Gray register, `s1`, `s2` and overflow all load 0.
  - After reset, all outputs are 0, including `w_full_o`, because 0 ≠ {11,0…}.
  - A reset mid-stream discards pointer state. The system must reset the read side in the same window.
  - While `reset_n_i=0`, `w_accept_o` is forced to 0.
- Full and a read-pointer change in the same cycle: `w_full_o` reflects the current `s2` only. The write is refused, and the freed slot becomes visible two edges after `r_ptr_gray_i` changes.

## Timing
- Accepted write in cycle n: `w_ptr_binary_o` and `w_ptr_gray_o` show the new value in cycle n+1.
- `w_full_o` follows the pointer in the same cycle (n+1).
- Synchronizer latency: a value stable on `r_ptr_gray_i` before edge k appears on `r_ptr_gray_sync_o` after edge k+1.
- The full flag is conservative: it may stay high for up to 2 cycles after the read side frees a slot. It never deasserts early.
- Throughput: one write per cycle while not full.

## Test plan
- **Reset:** `reset_n_i=0` for 2 cycles with `w_enq_i=1` and `r_ptr_gray_i=4'b1010`.
  - Required: `w_accept_o=0` throughout; all outputs 0 and `w_full_o=0` after reset.
- **Fill** (`lg_size_p=3`, `r_ptr_gray_i=0`): 8 back-to-back enqueues.
  - Required: `w_ptr_binary_o=8`, `w_ptr_gray_o=4'b1100`, `w_full_o=1` in the cycle after the 8th accept.
  - A 9th `w_enq_i` gives `w_accept_o=0`, pointers unchanged, and `w_overflow_o=1` the next cycle, remaining 1 until reset.
- **Drain release:** from full, drive `r_ptr_gray_i=4'b0001` (read pointer = 1) before edge k.
  - Required: `r_ptr_gray_sync_o=0001` and `w_full_o=0` after edge k+1; the next enqueue is accepted and makes `w_full_o=1` again (binary 9, Gray 1101).
- **Wrap** (`lg_size_p=3`): 16 enqueues with the reader tracking the writer (no full).
  - Required: binary goes 1111→0000 and Gray goes 1000→0000; no overflow.
- **Gray property** (default width): 65,536 enqueues with the reader tracking.
  - Required: every `w_ptr_gray_o` transition has Hamming distance exactly 1, and each value equals `gray(w_ptr_binary_o)` every cycle.
- **Simultaneous events:** while full, assert `w_enq_i` in the same cycle that `r_ptr_gray_i` changes.
  - Required: the write is refused, overflow is set, and `w_full_o` deasserts exactly 2 edges later.

Source files
------------

// File: rtl/bsg_async_fifo_wptr_gray.sv
// Write-side pointer unit of a dual-clock FIFO: binary/Gray write pointers,
// 2-flop synchronizer for the read Gray pointer, full and sticky overflow flags.
module bsg_async_fifo_wptr_gray #(
    parameter int unsigned lg_size_p = 15
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 w_enq_i,
    input  logic [lg_size_p:0]   r_ptr_gray_i,
    output logic                 w_full_o,
    output logic                 w_accept_o,
    output logic [lg_size_p:0]   w_ptr_binary_o,
    output logic [lg_size_p:0]   w_ptr_gray_o,
    output logic [lg_size_p:0]   r_ptr_gray_sync_o,
    output logic                 w_overflow_o
);

    localparam int unsigned ptr_w_lp = lg_size_p + 1;

    logic [ptr_w_lp-1:0] b_q, b_d;
    logic [ptr_w_lp-1:0] gray_q, gray_d;
    logic [ptr_w_lp-1:0] s1_q, s2_q;
    logic [ptr_w_lp-1:0] full_pattern;
    logic                ovf_q, ovf_d;

    // Full when the writer is exactly one lap ahead of the synchronized reader.
    if (lg_size_p == 1) begin : g_narrow
        assign full_pattern = ~s2_q;
    end else begin : g_wide
        assign full_pattern = {~s2_q[ptr_w_lp-1 -: 2], s2_q[ptr_w_lp-3:0]};
    end

    always_comb begin
        w_full_o   = (gray_q == full_pattern);
        w_accept_o = reset_n_i & w_enq_i & ~w_full_o;
        b_d        = b_q + ptr_w_lp'(w_accept_o);
        gray_d     = b_d ^ (b_d >> 1);
        ovf_d      = ovf_q | (w_enq_i & w_full_o);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            b_q    <= '0;
            gray_q <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            ovf_q  <= 1'b0;
        end else begin
            b_q    <= b_d;
            gray_q <= gray_d;
            s1_q   <= r_ptr_gray_i;
            s2_q   <= s1_q;
            ovf_q  <= ovf_d;
        end
    end

    assign w_ptr_binary_o    = b_q;
    assign w_ptr_gray_o      = gray_q;
    assign r_ptr_gray_sync_o = s2_q;
    assign w_overflow_o      = ovf_q;

endmodule

// File: tb/tb_bsg_async_fifo_wptr_gray.sv
// Directed bench: a depth-8 instance for fill/overflow/drain/wrap corners and a
// default-width instance for the full-range Gray single-bit-change property.
module tb_bsg_async_fifo_wptr_gray;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // depth-8 instance
    logic       rst_s, enq_s, full_s, acc_s, ovf_s;
    logic [3:0] rptr_s, bin_s, gray_s, sync_s;

    bsg_async_fifo_wptr_gray #(.lg_size_p(3)) dut_s (
        .clk_i(clk), .reset_n_i(rst_s), .w_enq_i(enq_s), .r_ptr_gray_i(rptr_s),
        .w_full_o(full_s), .w_accept_o(acc_s), .w_ptr_binary_o(bin_s),
        .w_ptr_gray_o(gray_s), .r_ptr_gray_sync_o(sync_s), .w_overflow_o(ovf_s)
    );

    // default-width instance
    logic        rst_d, enq_d, full_d, acc_d, ovf_d;
    logic [15:0] rptr_d, bin_d, gray_d, sync_d;

    bsg_async_fifo_wptr_gray dut_d (
        .clk_i(clk), .reset_n_i(rst_d), .w_enq_i(enq_d), .r_ptr_gray_i(rptr_d),
        .w_full_o(full_d), .w_accept_o(acc_d), .w_ptr_binary_o(bin_d),
        .w_ptr_gray_o(gray_d), .r_ptr_gray_sync_o(sync_d), .w_overflow_o(ovf_d)
    );

    typedef struct {
        logic       rst;
        logic       enq;
        logic [3:0] rptr;
        logic       acc;    // expected before the edge
        logic [3:0] bin;    // expected after the edge
        logic [3:0] gray;
        logic [3:0] sync;
        logic       full;
        logic       ovf;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    function automatic logic [3:0] g4(input logic [3:0] x);
        return x ^ (x >> 1);
    endfunction

    function automatic logic [15:0] g16(input logic [15:0] x);
        return x ^ (x >> 1);
    endfunction

    function automatic vec_t mk(input logic rst, input logic enq, input logic [3:0] rptr,
                                input logic acc, input logic [3:0] bin, input logic [3:0] gray,
                                input logic [3:0] sync, input logic full, input logic ovf);
        vec_t v;
        v.rst = rst; v.enq = enq; v.rptr = rptr; v.acc = acc; v.bin = bin;
        v.gray = gray; v.sync = sync; v.full = full; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic edge_s();
        @(posedge clk);
        #1;
    endtask

    task automatic fill8();
        for (int k = 1; k <= 8; k++) begin
            enq_s = 1'b1; rptr_s = 4'b0000;
            #1 chk("fill_acc", 32'(acc_s), 32'd1);
            edge_s();
        end
        chk("fill_full", 32'(full_s), 32'd1);
    endtask

    initial begin
        logic [3:0]  model;
        logic [15:0] model_d, prev_gray;

        rst_s = 1'b0; enq_s = 1'b0; rptr_s = '0;
        rst_d = 1'b0; enq_d = 1'b0; rptr_d = '0;

        // reset, fill, overflow, drain release, refill, reset again
        vecs.push_back(mk(0, 1, 4'b1010, 0, 4'd0, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 1, 4'b1010, 0, 4'd0, 4'b0000, 4'b0000, 0, 0));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(1, 1, 4'b0000, 1, 4'(k), g4(4'(k)), 4'b0000, k == 8, 0));
        vecs.push_back(mk(1, 1, 4'b0000, 0, 4'd8, 4'b1100, 4'b0000, 1, 1));
        vecs.push_back(mk(1, 0, 4'b0001, 0, 4'd8, 4'b1100, 4'b0000, 1, 1));
        vecs.push_back(mk(1, 0, 4'b0001, 0, 4'd8, 4'b1100, 4'b0001, 0, 1));
        vecs.push_back(mk(1, 1, 4'b0001, 1, 4'd9, 4'b1101, 4'b0001, 1, 1));
        vecs.push_back(mk(1, 0, 4'b0001, 0, 4'd9, 4'b1101, 4'b0001, 1, 1));
        vecs.push_back(mk(0, 1, 4'b0001, 0, 4'd0, 4'b0000, 4'b0000, 0, 0));

        foreach (vecs[i]) begin
            rst_s = vecs[i].rst; enq_s = vecs[i].enq; rptr_s = vecs[i].rptr;
            #1 chk($sformatf("v%0d_acc", i), 32'(acc_s), 32'(vecs[i].acc));
            edge_s();
            chk($sformatf("v%0d_bin", i),  32'(bin_s),  32'(vecs[i].bin));
            chk($sformatf("v%0d_gray", i), 32'(gray_s), 32'(vecs[i].gray));
            chk($sformatf("v%0d_sync", i), 32'(sync_s), 32'(vecs[i].sync));
            chk($sformatf("v%0d_full", i), 32'(full_s), 32'(vecs[i].full));
            chk($sformatf("v%0d_ovf", i),  32'(ovf_s),  32'(vecs[i].ovf));
        end

        // wrap with the reader tracking the writer
        rst_s = 1'b1;
        model = 4'd0;
        for (int i = 0; i < 16; i++) begin
            enq_s = 1'b1; rptr_s = g4(model);
            #1 chk("wrap_acc", 32'(acc_s), 32'd1);
            edge_s();
            model = model + 4'd1;
            chk("wrap_bin", 32'(bin_s), 32'(model));
            chk("wrap_gray", 32'(gray_s), 32'(g4(model)));
            chk("wrap_full", 32'(full_s), 32'd0);
            if (i == 14) begin
                chk("wrap_bin15", 32'(bin_s), 32'b1111);
                chk("wrap_gray15", 32'(gray_s), 32'b1000);
            end
        end
        chk("wrap_bin0", 32'(bin_s), 32'd0);
        chk("wrap_gray0", 32'(gray_s), 32'd0);
        chk("wrap_ovf", 32'(ovf_s), 32'd0);

        // full, then enqueue in the same cycle the read pointer advances
        rst_s = 1'b0; enq_s = 1'b0; rptr_s = 4'b0000;
        edge_s();
        rst_s = 1'b1;
        fill8();
        enq_s = 1'b1; rptr_s = 4'b0001;
        #1 chk("sim_acc", 32'(acc_s), 32'd0);
        edge_s();
        chk("sim_ovf", 32'(ovf_s), 32'd1);
        chk("sim_full_e1", 32'(full_s), 32'd1);
        chk("sim_bin_e1", 32'(bin_s), 32'd8);
        enq_s = 1'b0;
        edge_s();
        chk("sim_full_e2", 32'(full_s), 32'd0);
        chk("sim_sync_e2", 32'(sync_s), 32'b0001);
        chk("sim_ovf_hold", 32'(ovf_s), 32'd1);
        enq_s = 1'b0;

        // default width: reset state then full-range Gray property
        chk("d_rst_bin", 32'(bin_d), 32'd0);
        chk("d_rst_gray", 32'(gray_d), 32'd0);
        chk("d_rst_full", 32'(full_d), 32'd0);
        chk("d_rst_sync", 32'(sync_d), 32'd0);
        rst_d = 1'b1;
        model_d = 16'd0;
        prev_gray = 16'd0;
        for (int i = 0; i < 65536; i++) begin
            enq_d = 1'b1; rptr_d = g16(model_d);
            #1 chk("d_acc", 32'(acc_d), 32'd1);
            edge_s();
            model_d = model_d + 16'd1;
            chk("d_bin", 32'(bin_d), 32'(model_d));
            chk("d_gray", 32'(gray_d), 32'(g16(model_d)));
            chk("d_hamming", 32'($countones(gray_d ^ prev_gray)), 32'd1);
            prev_gray = gray_d;
        end
        enq_d = 1'b0;
        chk("d_wrap_bin", 32'(bin_d), 32'd0);
        chk("d_ovf", 32'(ovf_d), 32'd0);
        chk("d_full", 32'(full_d), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
